// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO in front of the UART transmitter wrapper.
// Producers push bytes with a one-cycle isNew strobe at any rate; the queue
// issues them to the transmitter one at a time through its ready/isNew
// handshake, in push order.
// Optional build macro: UART_TXQ_OVF_STICKY_EN
//   defined     -> overflow latches on the first dropped push until reset
//   not defined -> overflow pulses for one cycle after each dropped push
module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     isNew,
    input  logic [7:0]               message,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     tx_ready,
    output logic                     tx_isNew,
    output logic [7:0]               tx_message
);
    localparam int PW = $clog2(DEPTH);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [PW:0]   CNT_FULL   = (PW + 1)'(DEPTH);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOLD       = 2'd1,
        WAIT_READY = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [GW-1:0]   guard;
    logic            pop;
    logic            push;
    logic            drop;
    logic [PW:0]     count_nxt;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: issue from IDLE, then wait for the transmitter to go
    // busy (or the guard to expire) and become ready again
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((count != '0) && tx_ready) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!tx_ready) begin
                    state_nxt = WAIT_READY;
                end else if (guard == GUARD_LAST) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_READY: begin
                if (tx_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop/push/drop decisions and the next occupancy
    always_comb begin
        pop       = (state == IDLE) && (count != '0) && tx_ready;
        push      = isNew && ((count != CNT_FULL) || pop);
        drop      = isNew && !push;
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Byte storage; contents need no reset because count gates every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= message;
        end
    end

    // Pointers, occupancy, guard counter and registered transmitter outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            guard      <= '0;
            tx_isNew   <= 1'b0;
            tx_message <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                tx_message <= mem[rd_ptr];
                guard      <= '0;
            end else if (state == HOLD) begin
                guard <= guard + 1'b1;
            end
            tx_isNew <= pop;
            count    <= count_nxt;
            full     <= (count_nxt == CNT_FULL);
`ifdef UART_TXQ_OVF_STICKY_EN
            overflow <= overflow | drop;
`else
            overflow <= drop;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed bench for uart_tx_queue with a small
// transmitter model (ready drops one cycle after an issue, rises 100 later).
module tb_uart_tx_queue;
    localparam int DEPTH        = 16;
    localparam int GUARD_CYCLES = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       isNew;
    logic [7:0] message;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       tx_ready;
    logic       tx_isNew;
    logic [7:0] tx_message;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] got[$];
    int         got_cyc[$];
    logic       prev_isnew = 1'b0;
    int         ovf_hi = 0;
    bit         model_en = 1'b0;
    bit         pend = 1'b0;
    int         busy_cnt = 0;

    uart_tx_queue #(
        .DEPTH        (DEPTH),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .isNew      (isNew),
        .message    (message),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .tx_ready   (tx_ready),
        .tx_isNew   (tx_isNew),
        .tx_message (tx_message)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < got_cyc.size()) return got_cyc[i];
        return -1000;
    endfunction

    // Advance one clock, sample outputs 1 time unit after the edge, run the
    // transmitter model.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        check("no_back_to_back", 32'(prev_isnew & tx_isNew), 0);
        prev_isnew = tx_isNew;
        if (tx_isNew === 1'b1) begin
            got.push_back(tx_message);
            got_cyc.push_back(cyc);
        end
        if (overflow === 1'b1) ovf_hi++;
        if (model_en) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_ready = 1'b1;
            end
            if (pend) begin
                tx_ready = 1'b0;
                busy_cnt = 100;
                pend     = 1'b0;
            end
            if (tx_isNew === 1'b1) pend = 1'b1;
        end
    endtask

    task automatic wait_issues(input int n, input int budget, input string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(got.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int dmin;
        int dmax;
        int d;
        reset    = 1'b0;
        isNew    = 1'b0;
        message  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_isnew", 32'(tx_isNew), 0);
        check("rst_msg",   32'(tx_message), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full",  32'(full), 0);
        check("rst_ovf",   32'(overflow), 0);

        // single byte latency
        reset   = 1'b1;
        isNew   = 1'b1;
        message = 8'h41;
        tick();
        isNew = 1'b0;
        check("t1_count_push", 32'(count), 1);
        check("t1_isnew_n1",   32'(tx_isNew), 0);
        tick();
        check("t1_isnew_n2",   32'(tx_isNew), 1);
        check("t1_msg_n2",     32'(tx_message), 'h41);
        check("t1_count_pop",  32'(count), 0);
        tick();
        check("t1_isnew_n3",   32'(tx_isNew), 0);
        repeat (10) tick();

        // three bytes against a slow transmitter
        got.delete();
        got_cyc.delete();
        model_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            isNew   = 1'b1;
            message = 8'h61 + 8'(i);
            tick();
        end
        isNew = 1'b0;
        repeat (50) tick();
        check("t2_one_issue_while_busy", 32'(got.size()), 1);
        wait_issues(3, 400, "t2_issue_timeout");
        check("t2_byte0", 32'(got_at(0)), 'h61);
        check("t2_byte1", 32'(got_at(1)), 'h62);
        check("t2_byte2", 32'(got_at(2)), 'h63);
        check("t2_gap01", 32'(cyc_at(1) - cyc_at(0)), 103);
        check("t2_gap12", 32'(cyc_at(2) - cyc_at(1)), 103);
        repeat (110) tick();
        model_en = 1'b0;
        tx_ready = 1'b1;
        repeat (10) tick();
        check("t2_count_end", 32'(count), 0);

        // fill past DEPTH with transmitter not ready
        got.delete();
        got_cyc.delete();
        ovf_hi   = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            isNew   = 1'b1;
            message = 8'(i);
            tick();
            if (i == DEPTH - 2) begin
                check("t3_full_at_15",  32'(full), 0);
                check("t3_count_at_15", 32'(count), 15);
            end
            if (i == DEPTH - 1) begin
                check("t3_full_at_16",  32'(full), 1);
                check("t3_count_at_16", 32'(count), 16);
                check("t3_ovf_before",  32'(overflow), 0);
            end
        end
        isNew = 1'b0;
        tick();
        check("t3_count_final", 32'(count), 16);
        check("t3_full_final",  32'(full), 1);
        check("t3_no_issue",    32'(got.size()), 0);
`ifdef UART_TXQ_OVF_STICKY_EN
        check("t3_ovf_cycles",  32'(ovf_hi), 3);
        check("t3_ovf_level",   32'(overflow), 1);
`else
        check("t3_ovf_cycles",  32'(ovf_hi), 2);
        check("t3_ovf_level",   32'(overflow), 0);
`endif

        // push into full queue in the same cycle as a pop, then drain at full rate
        tx_ready = 1'b1;
        isNew    = 1'b1;
        message  = 8'hAA;
        tick();
        isNew = 1'b0;
        check("t4_count_stays", 32'(count), 16);
        check("t4_full_stays",  32'(full), 1);
        check("t4_issue",       32'(tx_isNew), 1);
        check("t4_first_byte",  32'(tx_message), 'h00);
`ifdef UART_TXQ_OVF_STICKY_EN
        check("t4_ovf", 32'(overflow), 1);
`else
        check("t4_ovf", 32'(overflow), 0);
`endif
        wait_issues(DEPTH + 1, 300, "t4_drain_timeout");
        repeat (10) tick();
        check("t4_count_empty", 32'(count), 0);
        check("t4_full_empty",  32'(full), 0);
        check("t4_issue_total", 32'(got.size()), 17);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t4_byte%0d", i), 32'(got_at(i)), 32'(i));
        end
        check("t4_last_aa", 32'(got_at(DEPTH)), 'hAA);
        dmin = 1000;
        dmax = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            d = cyc_at(i) - cyc_at(i - 1);
            if (d < dmin) dmin = d;
            if (d > dmax) dmax = d;
        end
        check("t5_min_spacing", 32'(dmin), GUARD_CYCLES + 1);
        check("t5_max_spacing", 32'(dmax), GUARD_CYCLES + 1);

        // reset with 5 bytes queued while waiting for ready
        got.delete();
        got_cyc.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            isNew   = 1'b1;
            message = 8'hC0 + 8'(i);
            tick();
        end
        isNew    = 1'b0;
        tx_ready = 1'b1;
        tick();
        check("t6_issue", 32'(tx_isNew), 1);
        tx_ready = 1'b0;
        tick();
        tick();
        check("t6_count_5", 32'(count), 5);
        check("t6_msg_c0",  32'(tx_message), 'hC0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_isnew", 32'(tx_isNew), 0);
        check("t6_rst_msg",   32'(tx_message), 0);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_full",  32'(full), 0);
        check("t6_rst_ovf",   32'(overflow), 0);
        tick();
        tick();
        reset    = 1'b1;
        tx_ready = 1'b1;
        got.delete();
        got_cyc.delete();
        repeat (20) tick();
        check("t6_no_issue_after", 32'(got.size()), 0);
        check("t6_count_after",    32'(count), 0);
        isNew   = 1'b1;
        message = 8'h5A;
        tick();
        isNew = 1'b0;
        tick();
        check("t6_new_issue", 32'(tx_isNew), 1);
        check("t6_new_msg",   32'(tx_message), 'h5A);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
